// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetch/advance controller around a 16-bit program counter.
//                Reads pc, fetches the instruction word through a ready
//                handshake and holds it in ir for the execute stage. When
//                the execute stage reports completion, it issues a one-cycle
//                registered pcsignal pulse that clocks the program counter.
//                A HALT opcode stops sequencing, and a memory that never
//                answers within TIMEOUT wait cycles latches fetch_err.
//  Ports       : clk, rst            - clock / asynchronous active-high reset
//                run                 - start/continue request (IDLE, SETTLE)
//                pc                  - current program counter value
//                imem_addr, imem_rd  - program memory request
//                imem_ready, imem_data - program memory response
//                ir, opcode, ir_valid - instruction register towards execute
//                exec_done           - execute stage finished ir
//                pcsignal            - registered pulse, clocks the pc
//                halted, fetch_err   - sticky terminal status flags
//                instr_count         - retired instruction count (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                  DATA_W      = 16,
    parameter int                  ADDR_W      = 16,
    parameter int                  OPCODE_W    = 4,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF,
    parameter int                  TIMEOUT     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_rd,
    input  logic                imem_ready,
    input  logic [DATA_W-1:0]   imem_data,
    output logic [DATA_W-1:0]   ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic                ir_valid,
    input  logic                exec_done,
    output logic                pcsignal,
    output logic                halted,
    output logic                fetch_err,
    output logic [15:0]         instr_count
);

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int                c_cnt_w   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_WAIT    = 4'd2,
        S_DECODE  = 4'd3,
        S_EXEC    = 4'd4,
        S_ADVANCE = 4'd5,
        S_SETTLE  = 4'd6,
        S_HALT    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_to_cnt;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic                r_imem_rd;
    logic [DATA_W-1:0]   r_ir;
    logic                r_ir_valid;
    logic                r_pcsignal;
    logic                r_halted;
    logic                r_fetch_err;
    logic [15:0]         r_instr_count;
    logic [OPCODE_W-1:0] w_opcode;

    assign w_opcode = r_ir[DATA_W-1 -: OPCODE_W];

    // ------------------------------------------------------------------------
    // Sequencer. Every output is a flop so pcsignal, which the program
    // counter uses as its clock, can never glitch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_imem_addr   <= '0;
            r_imem_rd     <= 1'b0;
            r_ir          <= '0;
            r_ir_valid    <= 1'b0;
            r_pcsignal    <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_imem_addr <= pc;
                    r_imem_rd   <= 1'b1;
                    r_to_cnt    <= '0;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    // A response on the last allowed wait cycle still wins
                    // over the timeout.
                    if (imem_ready) begin
                        r_ir      <= imem_data;
                        r_imem_rd <= 1'b0;
                        r_state   <= S_DECODE;
                    end else if (r_to_cnt == c_to_last) begin
                        r_imem_rd   <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_cnt_w'(1);
                    end
                end

                S_DECODE: begin
                    // HALT is never handed to execute and never retired.
                    if (w_opcode == HALT_OPCODE) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_ir_valid <= 1'b1;
                        r_state    <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (exec_done) begin
                        r_ir_valid    <= 1'b0;
                        r_pcsignal    <= 1'b1;
                        r_instr_count <= r_instr_count + 16'd1;
                        r_state       <= S_ADVANCE;
                    end
                end

                S_ADVANCE: begin
                    r_pcsignal <= 1'b0;
                    r_state    <= S_SETTLE;
                end

                S_SETTLE: begin
                    // One spare cycle so the incremented pc is stable
                    // before the next FETCH samples it.
                    if (run) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_HALT: begin
                    r_halted <= 1'b1;
                end

                S_ERROR: begin
                    r_fetch_err <= 1'b1;
                    r_imem_rd   <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = r_imem_addr;
    assign imem_rd     = r_imem_rd;
    assign ir          = r_ir;
    assign opcode      = w_opcode;
    assign ir_valid    = r_ir_valid;
    assign pcsignal    = r_pcsignal;
    assign halted      = r_halted;
    assign fetch_err   = r_fetch_err;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed testbench for fetch_sequencer with a behavioural
//                program counter and a program memory of configurable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] pc;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic        ir_valid;
    logic        exec_done;
    logic        pcsignal;
    logic        halted;
    logic        fetch_err;
    logic [15:0] instr_count;

    int          n_err;
    int          n_checks;
    int          pulse_cnt;
    int          rd_rise;
    int unsigned wait_cnt;
    int unsigned mem_lat;
    logic [15:0] mem [16];

    fetch_sequencer #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .OPCODE_W    (4),
        .HALT_OPCODE (4'hF),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .pc          (pc),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .ir          (ir),
        .opcode      (opcode),
        .ir_valid    (ir_valid),
        .exec_done   (exec_done),
        .pcsignal    (pcsignal),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter clocked by pcsignal, sharing the reset.
    always @(posedge pcsignal or posedge rst) begin
        if (rst) pc <= 16'h0000;
        else     pc <= pc + 16'h0001;
    end

    always @(posedge pcsignal) pulse_cnt <= pulse_cnt + 1;
    always @(posedge imem_rd)  rd_rise   <= rd_rise + 1;

    // Memory answers after mem_lat cycles of an outstanding read.
    always @(posedge clk or posedge rst) begin
        if (rst)          wait_cnt <= 0;
        else if (imem_rd) wait_cnt <= wait_cnt + 1;
        else              wait_cnt <= 0;
    end

    always_comb begin
        imem_ready = imem_rd && (wait_cnt == mem_lat);
        imem_data  = mem[imem_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int i;
        int p0;
        int r0;
        logic ok;
        n_err = 0; n_checks = 0; pulse_cnt = 0; rd_rise = 0;
        for (int k = 0; k < 16; k++) mem[k] = 16'h0000;
        run = 1'b0; exec_done = 1'b0; mem_lat = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        step(2);

        // ---- reset state
        check("rst_imem_rd",   {31'd0, imem_rd},  32'd0);
        check("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
        check("rst_flags",     {28'd0, ir_valid, pcsignal, halted, fetch_err}, 32'd0);
        check("rst_ir_count",  {ir, instr_count}, 32'd0);

        // ---- single instruction, zero latency, 6-cycle period
        mem[0] = 16'h1234; mem[1] = 16'h5555;
        rst = 1'b0; run = 1'b1; exec_done = 1'b1;
        step(2);  // WAIT
        check("t1_wait_rd_addr", {imem_rd, imem_addr}, {1'b1, 16'h0000});
        step(1);  // DECODE
        check("t1_ir", {16'd0, ir}, 32'h1234);
        check("t1_opcode", {28'd0, opcode}, 32'h1);
        step(1);  // EXEC
        check("t1_ir_valid", {31'd0, ir_valid}, 32'd1);
        step(1);  // ADVANCE
        check("t1_pcsignal_cnt", {pcsignal, instr_count}, {1'b1, 16'd1});
        step(1);  // SETTLE
        check("t1_pulse_pc", {pcsignal, pc}, {1'b0, 16'd1});
        step(2);  // next WAIT, six cycles after the first
        check("t1_next_fetch", {imem_rd, imem_addr}, {1'b1, 16'h0001});

        // ---- asynchronous reset during WAIT
        #2 rst = 1'b1;
        #1;
        check("t6_rst_wait", {imem_rd, imem_addr, instr_count}, 33'd0);
        check("t6_rst_pc", {16'd0, pc}, 32'd0);

        // ---- imem_ready delayed 5 cycles
        step(1);
        mem[0] = 16'hABCD; mem_lat = 5;
        rst = 1'b0; run = 1'b1;
        step(2);
        i = 0;
        while (imem_rd && i < 20) begin i++; step(1); end
        check("t2_rd_cycles", i, 32'd6);
        check("t2_ir", {16'd0, ir}, 32'hABCD);
        check("t2_no_err", {31'd0, fetch_err}, 32'd0);
        run = 1'b0;
        step(4);  // EXEC, ADVANCE, SETTLE, IDLE
        check("t2_count_pc", {instr_count, pc}, {16'd1, 16'd1});

        // ---- exec_done withheld 10 cycles, run dropped mid-instruction
        mem[1] = 16'h3C3C; mem_lat = 0; exec_done = 1'b0; run = 1'b1;
        p0 = pulse_cnt;
        step(2);
        check("t5_fetch_addr", {imem_rd, imem_addr}, {1'b1, 16'h0001});
        step(2);  // EXEC
        run = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(ir_valid === 1'b1 && ir === 16'h3C3C && pcsignal === 1'b0)) ok = 1'b0;
            step(1);
        end
        check("t5_hold", {31'd0, ok}, 32'd1);
        exec_done = 1'b1;
        step(1);  // ADVANCE
        check("t5_pulse", {31'd0, pcsignal}, 32'd1);
        step(1);
        exec_done = 1'b0;
        step(4);
        check("t5_one_pulse", pulse_cnt - p0, 32'd1);
        check("t5_idle", {imem_rd, ir_valid, instr_count, pc}, {2'b00, 16'd2, 16'd2});

        // ---- imem_ready never asserted
        rst = 1'b1;
        step(1);
        rst = 1'b0; mem_lat = 1000; run = 1'b1; exec_done = 1'b1;
        p0 = pulse_cnt;
        step(2);
        i = 0;
        while (imem_rd && i < 30) begin i++; step(1); end
        check("t3_wait_cycles", i, 32'd8);
        check("t3_err", {fetch_err, imem_rd}, {1'b1, 1'b0});
        step(6);
        check("t3_sticky", {fetch_err, imem_rd, pcsignal}, {1'b1, 1'b0, 1'b0});
        check("t3_no_pulse", pulse_cnt - p0, 32'd0);

        // ---- HALT program
        rst = 1'b1;
        step(1);
        mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'hF000;
        mem_lat = 0; rst = 1'b0; run = 1'b1; exec_done = 1'b1;
        p0 = pulse_cnt;
        i = 0;
        while (!halted && i < 60) begin i++; step(1); end
        check("t4_halted", {31'd0, halted}, 32'd1);
        check("t4_pulses", pulse_cnt - p0, 32'd2);
        check("t4_count_pc", {instr_count, pc}, {16'd2, 16'd2});
        check("t4_ir", {ir_valid, opcode, ir}, {1'b0, 4'hF, 16'hF000});
        r0 = rd_rise;
        step(10);
        check("t4_no_fetch", {imem_rd, pcsignal, halted}, {1'b0, 1'b0, 1'b1});
        check("t4_no_rd_rise", rd_rise - r0, 32'd0);

        // ---- asynchronous reset during the pcsignal cycle
        rst = 1'b1;
        step(1);
        mem[0] = 16'h1111; rst = 1'b0; run = 1'b1; exec_done = 1'b1;
        step(5);  // ADVANCE
        check("t6_adv_pulse", {pcsignal, instr_count}, {1'b1, 16'd1});
        #2 rst = 1'b1;
        #1;
        check("t6_rst_adv", {pcsignal, instr_count, ir}, 33'd0);
        check("t6_rst_adv_pc", {halted, fetch_err, pc}, 18'd0);
        step(1);
        rst = 1'b0;
        step(2);
        check("t6_restart", {imem_rd, imem_addr}, {1'b1, 16'h0000});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch/advance controller sitting directly upstream and downstream of the 16-bit program counter. It reads the current pc, fetches the instruction word from program memory through a ready handshake, and holds it in the instruction register for the execute stage. When the execute stage finishes, it drives a one-cycle pcsignal pulse that clocks the program counter forward. It also detects a HALT opcode and fetch timeouts.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 16, program address width; equals pc width
OPCODE_W, 4, opcode field width, taken from ir[DATA_W-1 -: OPCODE_W]
HALT_OPCODE, 4'hF, opcode that stops sequencing
TIMEOUT, 8, maximum cycles spent waiting for imem_ready before error (≥2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; start or continue sequencing from IDLE
pc  input  ADDR_W  current program counter value
imem_addr  output  ADDR_W  program memory address
imem_rd  output  1  memory read request
imem_ready  input  1  memory data valid this cycle
imem_data  input  DATA_W  memory read data
ir  output  DATA_W  instruction register
opcode  output  OPCODE_W  ir opcode field (combinational from ir)
ir_valid  output  1  ir holds an instruction awaiting execution
exec_done  input  1  execute stage finished the current ir
pcsignal  output  1  registered one-cycle pulse; clocks the program counter
halted  output  1  HALT opcode reached
fetch_err  output  1  imem_ready timeout
instr_count  output  16  instructions retired; wraps modulo 2^16

Behaviour:
- Reset (async, rst=1) does the following: state=IDLE; imem_addr=0; imem_rd=0; ir=0; ir_valid=0; pcsignal=0; halted=0; fetch_err=0; instr_count=0; timeout counter=0. The program counter shares rst, so pc=0 after reset.
- All outputs except opcode are registered, and pcsignal must be glitch-free because it is used as a clock.
- State machine:
  - IDLE: stay while run=0. When run=1, go to FETCH.
  - FETCH (1 cycle): imem_addr<=pc; imem_rd<=1; timeout counter<=0; go to WAIT.
  - WAIT: imem_rd stays 1.
    - imem_ready=1 → ir<=imem_data; imem_rd<=0; go to DECODE.
    - Otherwise the counter increments. When it reaches TIMEOUT-1 without ready → ERROR.
    - imem_ready is sampled only in WAIT; ready in any other state is ignored.
  - DECODE (1 cycle):
    - opcode==HALT_OPCODE → HALT. The HALT instruction is not counted.
    - Otherwise ir_valid<=1 → EXEC.
  - EXEC: hold ir and ir_valid until exec_done=1, then ir_valid<=0; pcsignal<=1; instr_count<=instr_count+1 → ADVANCE. If exec_done is already 1 on the first EXEC cycle, it is accepted.
  - ADVANCE (1 cycle): pcsignal<=0 → SETTLE.
  - SETTLE (1 cycle): lets the incremented pc propagate.
    - run=1 → FETCH.
    - run=0 → IDLE.
  - HALT: halted=1; no further pcsignal or imem_rd. Left only by rst.
  - ERROR: fetch_err=1; imem_rd=0; no pcsignal. Left only by rst.
- pcsignal is high for exactly one clk cycle per retired instruction, so the program counter increments exactly once per retired instruction. pc wraps 16'hFFFF→16'h0000 in the counter; this block treats the wrapped address normally.
- run is sampled only in IDLE and SETTLE. Deasserting run mid-instruction completes that instruction.
- exec_done outside EXEC is ignored.
- With imem_ready asserted on the first WAIT cycle and exec_done asserted on the first EXEC cycle, one instruction takes 6 cycles: FETCH, WAIT, DECODE, EXEC, ADVANCE, SETTLE.
- rst mid-operation (e.g. during WAIT with imem_rd=1, or with pcsignal=1) immediately forces all reset values. A pcsignal pulse truncated by reset is irrelevant, because the counter is also reset.

Test Plan:
- Reset then run=1; memory returns 16'h1234 on the first WAIT cycle; exec_done tied 1. Required: imem_addr=0 and imem_rd=1 in WAIT; ir=16'h1234; one pcsignal pulse; instr_count=1; next fetch address=1. Period is 6 cycles per instruction.
- imem_ready delayed 5 cycles with TIMEOUT=8. Required: imem_rd held high 6 cycles; correct ir captured; no fetch_err.
- imem_ready never asserted. Required: fetch_err=1 after TIMEOUT cycles in WAIT; imem_rd=0; no pcsignal ever; state persists until rst.
- Program 16'h0001, 16'h0002, 16'hF000. Required: two pcsignal pulses; halted=1; instr_count=2; pc=2; no further imem_rd.
- exec_done withheld 10 cycles. Required: ir_valid high and ir stable throughout; run dropped during EXEC still yields exactly one pcsignal, then IDLE.
- Assert rst during WAIT and during the ADVANCE/pcsignal cycle. Required: all outputs return to reset values asynchronously, without waiting for a clk edge; the next run restarts fetching at address 0.
